// File: rtl/gnn_0_example_load.sv
// Purpose : decodes one load instruction, kicks the DRAM read master, and streams
//           the returned beats into the on-chip buffer at consecutive (wrapping) addresses.
// Latency : buffer write lands 1 cycle after each AXIS handshake; one beat per cycle.
// Backpressure: s_axis_tready only while in STREAM with beats still owed; surplus beats stall.
//
// Ports:
//   aclk / areset             clock, synchronous active-high reset
//   ap_start / ap_done        launch pulse (honoured in IDLE only) / one-cycle completion pulse
//   ctrl_addr_offset          DRAM base address added to the instruction's dram_offset
//   ctrl_instruction          {xfer_size, dram_offset, beat_count, buf_start, unused} (16b fields, MSB first)
//   rd_ctrl_*                 read-master command: start pulse, done input, address, byte count
//   s_axis_*                  beat stream from the read master
//   load_write_buffer_*       buffer write port (valid / addr / data)
//   load_size_err             only with GNN_LOAD_SIZE_CHECK_EN: xfer_size disagrees with beat_count
//
// Build option: define GNN_LOAD_SIZE_CHECK_EN to add the load_size_err output and its check.

module gnn_0_example_load #(
    parameter int LOAD_INST_LENGTH   = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BUF_ADDR_WIDTH   = 11
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,

    output logic                          rd_ctrl_start,
    input  logic                          rd_ctrl_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  rd_ctrl_xfer_size_in_bytes,

    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,

`ifdef GNN_LOAD_SIZE_CHECK_EN
    output logic                          load_size_err,
`endif
    output logic                          load_write_buffer_valid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_data
);

    // ------------------------------------------------------------------
    // Instruction field decode (16-bit fields packed from the MSB down)
    // ------------------------------------------------------------------
    localparam int FIELD_W = 16;

    logic [FIELD_W-1:0] w_xfer_size;
    logic [FIELD_W-1:0] w_dram_offset;
    logic [FIELD_W-1:0] w_beat_count;
    logic [FIELD_W-1:0] w_buf_start;

    assign w_xfer_size   = ctrl_instruction[LOAD_INST_LENGTH-1  -: FIELD_W];
    assign w_dram_offset = ctrl_instruction[LOAD_INST_LENGTH-17 -: FIELD_W];
    assign w_beat_count  = ctrl_instruction[LOAD_INST_LENGTH-33 -: FIELD_W];
    assign w_buf_start   = ctrl_instruction[LOAD_INST_LENGTH-49 -: FIELD_W];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        STREAM  = 3'd2,
        WAIT_RD = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [FIELD_W-1:0]            r_beats_left;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_buf_addr;     // address the next accepted beat will use
    logic                          r_rd_done_seen; // sticky copy of rd_ctrl_done for this transfer
    logic                          r_ap_done;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_rd_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_xfer_size;
    logic                          r_wr_vld;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wr_data;

    logic w_start_acc;  // ap_start is only honoured while idle
    logic w_hs;         // beat accepted this cycle
    logic w_track_done; // states in which rd_ctrl_done is meaningful

    assign w_start_acc  = ap_start && (r_state == IDLE);
    assign w_hs         = s_axis_tvalid && s_axis_tready;
    assign w_track_done = (r_state == ISSUE) || (r_state == STREAM) || (r_state == WAIT_RD);

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        rd_ctrl_start = 1'b0;
        s_axis_tready = 1'b0;

        case (r_state)
            IDLE: begin
                if (ap_start) begin
                    // An empty load skips the read master entirely.
                    w_next_state = (w_beat_count != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                rd_ctrl_start = 1'b1;
                w_next_state  = STREAM;
            end
            STREAM: begin
                s_axis_tready = (r_beats_left != '0);
                if (r_beats_left == '0) begin
                    w_next_state = r_rd_done_seen ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (r_rd_done_seen) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= IDLE;
            r_beats_left   <= '0;
            r_buf_addr     <= '0;
            r_rd_done_seen <= 1'b0;
            r_ap_done      <= 1'b0;
            r_rd_addr      <= '0;
            r_xfer_size    <= '0;
            r_wr_vld       <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
        end else begin
            r_state <= w_next_state;

            // ap_done is the registered image of DONE, so it fires in the
            // cycle after DONE and lasts exactly one cycle.
            r_ap_done <= (r_state == DONE);

            if (w_start_acc) begin
                r_beats_left <= w_beat_count;
                r_buf_addr   <= w_buf_start[C_BUF_ADDR_WIDTH-1:0];
                // Carry out of the address width is intentionally dropped.
                r_rd_addr    <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(w_dram_offset);
                r_xfer_size  <= C_XFER_SIZE_WIDTH'(w_xfer_size);
            end

            // Write port: valid only in the cycle after a handshake;
            // address and data hold between writes.
            r_wr_vld <= w_hs;
            if (w_hs) begin
                r_wr_addr    <= r_buf_addr;
                r_wr_data    <= s_axis_tdata;
                r_buf_addr   <= r_buf_addr + C_BUF_ADDR_WIDTH'(1);  // wraps naturally
                r_beats_left <= r_beats_left - FIELD_W'(1);
            end

            if (w_next_state == IDLE) begin
                r_rd_done_seen <= 1'b0;
            end else if (w_track_done && rd_ctrl_done) begin
                r_rd_done_seen <= 1'b1;
            end
        end
    end

    assign ap_done                    = r_ap_done;
    assign rd_ctrl_addr_offset        = r_rd_addr;
    assign rd_ctrl_xfer_size_in_bytes = r_xfer_size;
    assign load_write_buffer_valid    = r_wr_vld;
    assign load_write_buffer_addr     = r_wr_addr;
    assign load_write_buffer_data     = r_wr_data;

`ifdef GNN_LOAD_SIZE_CHECK_EN
    // ------------------------------------------------------------------
    // Size consistency check: advisory only, the transfer is unaffected.
    // ------------------------------------------------------------------
    localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;

    logic [31:0] w_expected_bytes;
    logic        r_size_err;

    assign w_expected_bytes = 32'(w_beat_count) * 32'(BEAT_BYTES);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_size_err <= 1'b0;
        end else if (w_start_acc) begin
            r_size_err <= (32'(w_xfer_size) != w_expected_bytes);
        end
    end

    assign load_size_err = r_size_err;
`endif

endmodule

// File: tb/tb_gnn_0_example_load.sv
// Purpose : directed bench for gnn_0_example_load with a transfer-level reference model.
// Latency : model expects each buffer write one cycle after its AXIS handshake.
// Backpressure: stimulus drives tvalid patterns; model flags tready outside an open transfer.

module tb_gnn_0_example_load;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int BW = 11;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ap_start;
    logic          ap_done;
    logic [AW-1:0] ctrl_addr_offset;
    logic [95:0]   ctrl_instruction;
    logic          rd_ctrl_start;
    logic          rd_ctrl_done;
    logic [AW-1:0] rd_ctrl_addr_offset;
    logic [31:0]   rd_ctrl_xfer_size_in_bytes;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          load_write_buffer_valid;
    logic [BW-1:0] load_write_buffer_addr;
    logic [DW-1:0] load_write_buffer_data;
`ifdef GNN_LOAD_SIZE_CHECK_EN
    logic          load_size_err;
`endif

    always #5 aclk = ~aclk;

    gnn_0_example_load dut (
        .aclk                       (aclk),
        .areset                     (areset),
        .ap_start                   (ap_start),
        .ap_done                    (ap_done),
        .ctrl_addr_offset           (ctrl_addr_offset),
        .ctrl_instruction           (ctrl_instruction),
        .rd_ctrl_start              (rd_ctrl_start),
        .rd_ctrl_done               (rd_ctrl_done),
        .rd_ctrl_addr_offset        (rd_ctrl_addr_offset),
        .rd_ctrl_xfer_size_in_bytes (rd_ctrl_xfer_size_in_bytes),
        .s_axis_tvalid              (s_axis_tvalid),
        .s_axis_tready              (s_axis_tready),
        .s_axis_tdata               (s_axis_tdata),
`ifdef GNN_LOAD_SIZE_CHECK_EN
        .load_size_err              (load_size_err),
`endif
        .load_write_buffer_valid    (load_write_buffer_valid),
        .load_write_buffer_addr     (load_write_buffer_addr),
        .load_write_buffer_data     (load_write_buffer_data)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] beat_data(input int tag, input int idx);
        logic [31:0] w;
        w = 32'(tag * 256 + idx) ^ 32'hA5A5_0000;
        return {16{w}};
    endfunction

    // ------------------------------------------------------------------
    // Transfer-level model and per-cycle compare.
    // A transfer is open from an ap_start seen while no transfer is open
    // until ap_done; it owes beat_count beats written to buf_start+i (mod 2^11),
    // in arrival order, each one cycle after its handshake.
    // ------------------------------------------------------------------
    bit          m_busy      = 1'b0;
    int          m_left      = 0;
    bit [BW-1:0] m_addr      = '0;
    bit [BW-1:0] m_last_addr = '0;
    bit [DW-1:0] m_last_data = '0;
    bit [DW-1:0] m_pend_data = '0;
    bit          m_pend      = 1'b0;
    int          wr_cnt      = 0;
    int          done_cnt    = 0;
    int          start_cnt   = 0;
    logic [BW-1:0] wr_log[$];
    logic [DW-1:0] wd_log[$];

    always @(negedge aclk) begin
        chk("wr_valid", 64'(load_write_buffer_valid), 64'(m_pend));
        if (m_pend) begin
            chk("wr_addr", 64'(load_write_buffer_addr), 64'(m_addr));
            chk_w("wr_data", load_write_buffer_data, m_pend_data);
            m_last_addr = m_addr;
            m_last_data = m_pend_data;
            m_addr      = m_addr + 1'b1;
            wr_cnt++;
        end else begin
            chk("wr_addr_hold", 64'(load_write_buffer_addr), 64'(m_last_addr));
            chk_w("wr_data_hold", load_write_buffer_data, m_last_data);
        end
        if (load_write_buffer_valid) begin
            wr_log.push_back(load_write_buffer_addr);
            wd_log.push_back(load_write_buffer_data);
        end

        if (areset) begin
            m_busy      = 1'b0;
            m_left      = 0;
            m_pend      = 1'b0;
            m_last_addr = '0;
            m_last_data = '0;
        end else begin
            if (s_axis_tready) chk("tready_legal", 64'(m_busy && (m_left > 0)), 64'd1);
            m_pend      = s_axis_tvalid && s_axis_tready;
            m_pend_data = s_axis_tdata;
            if (m_pend) m_left--;
            if (rd_ctrl_start) start_cnt++;
            if (ap_done) begin
                done_cnt++;
                chk("done_after_all_beats", 64'(m_left), 64'd0);
                m_busy = 1'b0;
            end
            if (ap_start && !m_busy) begin
                m_busy = 1'b1;
                m_left = int'(ctrl_instruction[63:48]);
                m_addr = ctrl_instruction[32 +: BW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic launch(input logic [15:0] size, input logic [15:0] dram,
                          input logic [15:0] beats, input logic [15:0] bstart);
        @(posedge aclk); #1;
        ctrl_instruction = {size, dram, beats, bstart, 32'h0};
        ap_start = 1'b1;
        @(posedge aclk); #1;
        ap_start = 1'b0;
    endtask

    // Offers up to 'offers' beats for 30 cycles; tvalid follows vpat; rd_ctrl_done
    // pulses in the cycle after handshake number done_after; an extra ap_start
    // with a different instruction is pulsed at cycle restart_cyc (-1: none).
    task automatic stream(input int offers, input bit [7:0] vpat, input int done_after,
                          input int restart_cyc, input int tag);
        int idx = 0;
        bit done_sent = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge aclk); #1;
            s_axis_tvalid = (idx < offers) && vpat[cyc % 8];
            s_axis_tdata  = beat_data(tag, idx);
            rd_ctrl_done  = !done_sent && (idx >= done_after);
            if (rd_ctrl_done) done_sent = 1'b1;
            ap_start = (cyc == restart_cyc);
            if (ap_start) ctrl_instruction = {16'd64, 16'h0, 16'd1, 16'h0123, 32'h0};
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) idx++;
        end
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        rd_ctrl_done  = 1'b0;
        ap_start      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int wb, db, sb, hb;
    int hs;

    initial begin
        areset           = 1'b1;
        ap_start         = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_instruction = '0;
        rd_ctrl_done     = 1'b0;
        s_axis_tvalid    = 1'b0;
        s_axis_tdata     = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_ap_done",  64'(ap_done), 64'd0);
        chk("rst_rd_start", 64'(rd_ctrl_start), 64'd0);
        chk("rst_tready",   64'(s_axis_tready), 64'd0);
        chk("rst_rd_addr",  rd_ctrl_addr_offset, 64'd0);
        chk("rst_xfer",     64'(rd_ctrl_xfer_size_in_bytes), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;

        // Basic load: 4 beats to 0x010.., continuous tvalid, read done after beat 4
        ctrl_addr_offset = 64'h0000_0001_0000_0000;
        wb = wr_log.size(); db = done_cnt; sb = start_cnt;
        launch(16'd256, 16'h0040, 16'd4, 16'h0010);
        chk("basic_rd_addr", rd_ctrl_addr_offset, 64'h0000_0001_0000_0040);
        chk("basic_xfer",    64'(rd_ctrl_xfer_size_in_bytes), 64'd256);
`ifdef GNN_LOAD_SIZE_CHECK_EN
        chk("basic_size_err", 64'(load_size_err), 64'd0);
`endif
        stream(4, 8'hFF, 4, -1, 1);
        chk("basic_writes", 64'(wr_log.size() - wb), 64'd4);
        chk("basic_addr0", 64'(wr_log[wb]),   64'h010);
        chk("basic_addr3", 64'(wr_log[wb+3]), 64'h013);
        chk("basic_done",  64'(done_cnt - db), 64'd1);
        chk("basic_start", 64'(start_cnt - sb), 64'd1);

        // Backpressure gaps: tvalid 1,0,1,0...
        wb = wr_log.size(); db = done_cnt;
        launch(16'd192, 16'h0, 16'd3, 16'h0040);
        stream(3, 8'b0101_0101, 3, -1, 2);
        chk("bp_writes", 64'(wr_log.size() - wb), 64'd3);
        for (int i = 0; i < 3; i++) chk_w("bp_data_order", wd_log[wb+i], beat_data(2, i));
        chk("bp_addr2", 64'(wr_log[wb+2]), 64'h042);
        chk("bp_done",  64'(done_cnt - db), 64'd1);

        // Wrap-around at the top of the buffer; address carry also wraps
        ctrl_addr_offset = 64'hFFFF_FFFF_FFFF_FFF0;
        wb = wr_log.size();
        launch(16'd256, 16'h0020, 16'd4, 16'h07FE);
        chk("wrap_rd_addr", rd_ctrl_addr_offset, 64'h10);
        stream(4, 8'hFF, 4, -1, 3);
        chk("wrap_writes", 64'(wr_log.size() - wb), 64'd4);
        chk("wrap_a0", 64'(wr_log[wb]),   64'h7FE);
        chk("wrap_a1", 64'(wr_log[wb+1]), 64'h7FF);
        chk("wrap_a2", 64'(wr_log[wb+2]), 64'h000);
        chk("wrap_a3", 64'(wr_log[wb+3]), 64'h001);

        // Zero length: no read, no writes, ap_done two cycles after ap_start
        wb = wr_log.size(); db = done_cnt; sb = start_cnt;
        launch(16'd0, 16'h0, 16'd0, 16'h0100);
        @(negedge aclk);
        chk("zero_done_c1", 64'(ap_done), 64'd0);
        @(negedge aclk);
        chk("zero_done_c2", 64'(ap_done), 64'd1);
        @(negedge aclk);
        chk("zero_done_c3", 64'(ap_done), 64'd0);
        repeat (5) @(negedge aclk);
        chk("zero_writes", 64'(wr_log.size() - wb), 64'd0);
        chk("zero_start",  64'(start_cnt - sb), 64'd0);
        chk("zero_done",   64'(done_cnt - db), 64'd1);

        // Early read done, 2 surplus beats, second ap_start during STREAM
        ctrl_addr_offset = 64'h0000_0000_0000_8000;
        wb = wr_log.size(); db = done_cnt; sb = start_cnt;
        launch(16'd192, 16'h0010, 16'd3, 16'h0100);
        stream(5, 8'hFF, 1, 2, 4);
        chk("early_writes", 64'(wr_log.size() - wb), 64'd3);
        chk("early_a0", 64'(wr_log[wb]),   64'h100);
        chk("early_a2", 64'(wr_log[wb+2]), 64'h102);
        chk("early_done",  64'(done_cnt - db), 64'd1);
        chk("early_start", 64'(start_cnt - sb), 64'd1);
        chk("early_rd_addr", rd_ctrl_addr_offset, 64'h8010);

`ifdef GNN_LOAD_SIZE_CHECK_EN
        launch(16'd100, 16'h0, 16'd2, 16'h0300);
        chk("size_err_set", 64'(load_size_err), 64'd1);
        stream(2, 8'hFF, 2, -1, 6);
`endif

        // Reset mid-stream after 2 of 8 beats, with ap_start in the reset cycle
        wb = wr_log.size(); db = done_cnt; sb = start_cnt;
        launch(16'd512, 16'h0, 16'd8, 16'h0200);
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            @(posedge aclk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beat_data(5, hs);
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) hs++;
        end
        chk("rst_mid_beats_taken", 64'(hs), 64'd2);
        @(posedge aclk); #1;
        areset = 1'b1;
        ap_start = 1'b1;
        ctrl_instruction = {16'd320, 16'h0, 16'd5, 16'h0500, 32'h0};
        @(posedge aclk); #1;
        areset = 1'b0;
        ap_start = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("rst_mid_ap_done",  64'(ap_done), 64'd0);
        chk("rst_mid_rd_start", 64'(rd_ctrl_start), 64'd0);
        chk("rst_mid_tready",   64'(s_axis_tready), 64'd0);
        chk("rst_mid_wr_vld",   64'(load_write_buffer_valid), 64'd0);
        chk("rst_mid_wr_addr",  64'(load_write_buffer_addr), 64'd0);
        chk_w("rst_mid_wr_data", load_write_buffer_data, '0);
        chk("rst_mid_rd_addr",  rd_ctrl_addr_offset, 64'd0);
        chk("rst_mid_xfer",     64'(rd_ctrl_xfer_size_in_bytes), 64'd0);
`ifdef GNN_LOAD_SIZE_CHECK_EN
        chk("rst_mid_size_err", 64'(load_size_err), 64'd0);
`endif
        repeat (20) @(posedge aclk);
        #1;
        chk("rst_mid_writes", 64'(wr_log.size() - wb), 64'd2);
        chk("rst_mid_no_done", 64'(done_cnt - db), 64'd0);
        chk("rst_mid_start",  64'(start_cnt - sb), 64'd1);

        repeat (2) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
